// File: rtl/spi_slave_param.sv
// spi_slave_param: parameterised SPI slave (mode set by CPOL/CPHA, WIDTH-bit
// frames, MSB- or LSB-first) running entirely in the clk domain. SPI pins go
// through 2-flop synchronisers and im_sclk edges are found by comparing the
// synchronised level with its previous value.
// Optional feature macro: SPI_SLAVE_OVERRUN_EN adds the sticky overrun flag.
module spi_slave_param #(
  parameter int WIDTH     = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             im_sclk,
  input  logic             im_cs,
  input  logic             im_mosi,
  output logic             im_miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             busy
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  localparam int   CW          = $clog2(WIDTH) + 1;
  localparam logic SCLK_IDLE   = (CPOL != 0) ? 1'b1 : 1'b0;
  localparam bit   SAMPLE_RISE = (CPOL == CPHA);
  localparam bit   SKIP_FIRST  = (CPHA != 0);
  localparam bit   MSB_OUT     = (MSB_FIRST != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Move the register one place toward the outgoing end, inserting bit_in
  // at the incoming end.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word,
                                                input logic             bit_in);
    if (MSB_OUT) begin
      shift_in = {word[WIDTH-2:0], bit_in};
    end else begin
      shift_in = {bit_in, word[WIDTH-1:1]};
    end
  endfunction

  // Bit presented on im_miso for a given register value.
  function automatic logic out_bit(input logic [WIDTH-1:0] word);
    out_bit = MSB_OUT ? word[WIDTH-1] : word[0];
  endfunction

  // Synchroniser and edge-detect flops.
  logic cs_s1_q, cs_s2_q, sclk_s1_q, sclk_s2_q, sclk_prev_q, mosi_s1_q, mosi_s2_q;

  // Frame state. prime_q counts the cycles after reset until the synchroniser
  // outputs reflect the real pins; armed_q records that im_cs was seen high,
  // which is required before a new frame may start.
  state_e           state_q, state_d;
  logic [1:0]       prime_q, prime_d;
  logic             armed_q, armed_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             rx_bit_q, rx_bit_d;
  logic             skip_q, skip_d;
  logic [WIDTH-1:0] txbuf_q, txbuf_d;
  logic             txfull_q, txfull_d;
  logic             tx_ready_q, tx_ready_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             miso_q, miso_d;
  logic             busy_q, busy_d;

  logic sclk_rise_s, sclk_fall_s, sample_edge_s, shift_edge_s, done_s;

  assign sclk_rise_s   = sclk_s2_q & ~sclk_prev_q;
  assign sclk_fall_s   = ~sclk_s2_q & sclk_prev_q;
  assign sample_edge_s = SAMPLE_RISE ? sclk_rise_s : sclk_fall_s;
  assign shift_edge_s  = SAMPLE_RISE ? sclk_fall_s : sclk_rise_s;
  assign done_s        = (state_q == ST_DONE);

  assign im_miso  = miso_q;
  assign tx_ready = tx_ready_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;

  // Next-state, datapath and output computation for the frame FSM.
  always_comb begin
    state_d    = state_q;
    prime_d    = prime_q;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    rx_bit_d   = rx_bit_q;
    skip_d     = skip_q;
    txbuf_d    = txbuf_q;
    txfull_d   = txfull_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;

    if (prime_q != 2'd2) begin
      prime_d = prime_q + 2'd1;
    end else begin
      prime_d = prime_q;
    end

    if ((prime_q == 2'd2) && cs_s2_q) begin
      armed_d = 1'b1;
    end else begin
      armed_d = armed_q;
    end

    if (rx_ack) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        skip_d = SKIP_FIRST;
        if (!cs_s2_q && armed_q) begin
          state_d  = ST_SHIFT;
          armed_d  = 1'b0;
          shreg_d  = txfull_q ? txbuf_q : '0;
          txfull_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cs_s2_q) begin
          state_d = ST_IDLE;
        end else if (sample_edge_s) begin
          rx_bit_d = mosi_s2_q;
          cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end else if (shift_edge_s) begin
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            shreg_d = shift_in(shreg_q, rx_bit_q);
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // The last sampled bit is still held in rx_bit_q; fold it in here.
        state_d    = ST_IDLE;
        rx_data_d  = shift_in(shreg_q, rx_bit_q);
        rx_valid_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // tx_ready_q is the pre-start buffer state, so a load coinciding with a
    // start on an empty buffer refills it while the frame sends zeros.
    if (tx_load && tx_ready_q) begin
      txbuf_d  = tx_data;
      txfull_d = 1'b1;
    end else begin
      txbuf_d = txbuf_d;
    end

    tx_ready_d = ~txfull_d;
    busy_d     = (state_d != ST_IDLE);
    if (state_d == ST_SHIFT) begin
      miso_d = out_bit(shreg_d);
    end else begin
      miso_d = 1'b0;
    end
  end

  // Synchronisers plus all frame registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      sclk_s1_q   <= SCLK_IDLE;
      sclk_s2_q   <= SCLK_IDLE;
      sclk_prev_q <= SCLK_IDLE;
      mosi_s1_q   <= 1'b0;
      mosi_s2_q   <= 1'b0;
      state_q     <= ST_IDLE;
      prime_q     <= 2'd0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      rx_bit_q    <= 1'b0;
      skip_q      <= 1'b0;
      txbuf_q     <= '0;
      txfull_q    <= 1'b0;
      tx_ready_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cs_s1_q     <= im_cs;
      cs_s2_q     <= cs_s1_q;
      sclk_s1_q   <= im_sclk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      mosi_s1_q   <= im_mosi;
      mosi_s2_q   <= mosi_s1_q;
      state_q     <= state_d;
      prime_q     <= prime_d;
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      rx_bit_q    <= rx_bit_d;
      skip_q      <= skip_d;
      txbuf_q     <= txbuf_d;
      txfull_q    <= txfull_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q, overrun_d;

  assign overrun = overrun_q;

  // Sticky overrun: a word completes while the previous one is unacknowledged.
  always_comb begin
    overrun_d = overrun_q;
    if (done_s && rx_valid_q && !rx_ack) begin
      overrun_d = 1'b1;
    end else if (rx_ack && !done_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Overrun flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end
`else
  logic unused_done_s;
  assign unused_done_s = done_s;
`endif

endmodule
